// File: rtl/apb_fifo_slave.sv
// apb_fifo_slave: APB responder fronting a DEPTH x 32-bit FIFO with STATUS/CTRL/COUNT registers,
// programmable wait states and a level interrupt while enabled and data is pending.
module apb_fifo_slave #(
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count, count_next;
  logic irq_en, overflow, underflow;
  logic full, empty, commit, push, pop, ctrl_wr, flush;
  logic [1:0] addr;
  logic [31:0] rdata;
  logic unused_addr;
  assign addr        = PADDR[3:2];
  assign unused_addr = ^{PADDR[31:4], PADDR[1:0]};
  assign full        = count == (AW+1)'(DEPTH);
  assign empty       = count == '0;
  // the transfer's side effect lands on the edge that leaves ACK
  assign commit      = state == ACK;
  assign push        = commit & PWRITE & (addr == 2'd0);
  assign pop         = commit & ~PWRITE & (addr == 2'd0);
  assign ctrl_wr     = commit & PWRITE & (addr == 2'd2);
  assign flush       = ctrl_wr & PWDATA[1];
  assign count_next  = flush ? '0 :
                       (push & ~full) ? count + 1'b1 :
                       (pop & ~empty) ? count - 1'b1 : count;
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) begin
      state  <= IDLE;
      cnt    <= '0;
      PREADY <= 1'b0;
    end else begin
      PREADY <= 1'b0;
      case (state)
        IDLE: if (PSEL && !PENABLE) begin
          state <= WAIT;
          cnt   <= 4'(WAIT_STATES);
        end
        WAIT: if (!PSEL) state <= IDLE;
        else if (PENABLE) begin
          if (cnt == '0) begin
            state  <= ACK;
            PREADY <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      irq       <= 1'b0;
    end else begin
      count <= count_next;
      irq   <= irq_en & (count_next != '0);
      if (flush) begin
        wptr      <= '0;
        rptr      <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (push) begin
          if (full) overflow <= 1'b1;
          else wptr <= wptr + 1'b1;
        end
        if (pop) begin
          if (empty) underflow <= 1'b1;
          else rptr <= rptr + 1'b1;
        end
      end
      if (ctrl_wr) irq_en <= PWDATA[0];
    end
  // storage is left unreset; a flush only rewinds the pointers
  always_ff @(posedge PCLK)
    if (push && !full) mem[wptr] <= PWDATA;
  always_comb begin
    rdata = addr == 2'd0 ? (empty ? 32'h0 : mem[rptr]) :
            addr == 2'd1 ? {28'h0, underflow, overflow, full, empty} :
            addr == 2'd2 ? {31'h0, irq_en} : 32'(count);
  end
  assign PRDATA = PREADY ? rdata : 32'h0;
endmodule

// File: tb/tb_apb_fifo_slave.sv
// tb_apb_fifo_slave: directed APB transfers against apb_fifo_slave (DEPTH=8, WAIT_STATES=1).
module tb_apb_fifo_slave;
  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        irq;
  int errors = 0;
  int checks = 0;
  logic [31:0] rd;
  logic        irq_rdy;

  apb_fifo_slave #(.DEPTH(8), .WAIT_STATES(1)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // full transfer; PREADY expected WAIT_STATES+1 = 2 cycles after the first PENABLE cycle
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int lat;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    lat = 0;
    while (!PREADY && lat < 20) begin
      @(negedge PCLK);
      lat++;
    end
    rd = PRDATA;
    irq_rdy = irq;
    chk("latency", 32'(lat), 32'd2);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("pready_width", {31'h0, PREADY}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(1'b1, a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    xfer(1'b0, a, 32'h0);
    chk(tag, rd, exp);
  endtask

  initial begin
    repeat (2) @(negedge PCLK);
    chk("rst_pready", {31'h0, PREADY}, 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    PRESET = 1'b1;
    rd_chk("status_reset", 32'h4, 32'h1);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    // basic ordering
    wr(32'h0, 32'd10);
    wr(32'h0, 32'd11);
    wr(32'h0, 32'd12);
    rd_chk("count3", 32'hC, 32'd3);
    rd_chk("pop10", 32'h0, 32'd10);
    rd_chk("pop11", 32'h0, 32'd11);
    rd_chk("pop12", 32'h0, 32'd12);
    rd_chk("status_empty", 32'h4, 32'h1);
    // writes to read-only registers complete but change nothing
    wr(32'h4, 32'hFFFF_FFFF);
    wr(32'hC, 32'hFFFF_FFFF);
    rd_chk("status_ro", 32'h4, 32'h1);
    rd_chk("count_ro", 32'hC, 32'd0);
    // overfill from pointer 3 so the pointers wrap
    for (int i = 1; i <= 9; i++) wr(32'h0, 32'(i));
    rd_chk("status_full_ovf", 32'h4, 32'h6);
    rd_chk("count_full", 32'hC, 32'd8);
    for (int i = 1; i <= 8; i++) rd_chk("pop_wrap", 32'h0, 32'(i));
    rd_chk("status_sticky_ovf", 32'h4, 32'h5);
    wr(32'h8, 32'h2);
    rd_chk("status_flushed", 32'h4, 32'h1);
    rd_chk("pop_empty", 32'h0, 32'h0);
    rd_chk("status_udf", 32'h4, 32'h9);
    wr(32'h8, 32'h3);
    rd_chk("status_flush2", 32'h4, 32'h1);
    rd_chk("ctrl_rd", 32'h8, 32'h1);
    chk("irq_empty_en", {31'h0, irq}, 32'h0);
    // interrupt follows occupancy one cycle after the commit
    wr(32'h0, 32'd42);
    chk("irq_at_push_ready", {31'h0, irq_rdy}, 32'h0);
    chk("irq_after_push", {31'h0, irq}, 32'h1);
    rd_chk("pop42", 32'h0, 32'd42);
    chk("irq_at_pop_ready", {31'h0, irq_rdy}, 32'h1);
    chk("irq_after_pop", {31'h0, irq}, 32'h0);
    // aborted write: PSEL drops during WAIT
    wr(32'h0, 32'd7);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h55;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_no_ready0", {31'h0, PREADY}, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("abort_no_ready", {31'h0, PREADY}, 32'h0);
    end
    rd_chk("count_after_abort", 32'hC, 32'd1);
    // reset while PREADY is high
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'hC;
    @(negedge PCLK);
    PENABLE = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("rst_mid_ready", {31'h0, PREADY}, 32'h1);
    #1 PRESET = 1'b0;
    #1 chk("rst_mid_drop", {31'h0, PREADY}, 32'h0);
    chk("rst_mid_irq", {31'h0, irq}, 32'h0);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b1;
    rd_chk("count_after_rst", 32'hC, 32'd0);
    rd_chk("ctrl_after_rst", 32'h8, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
